// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall FSM, EX operand forwarding, branch flush, stall counter.
// Build option: define HAZARD_FWD_EN to enable forwarding; otherwise RAW hazards stall in ID.
module hazard_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int LOAD_LAT   = 1,
    parameter int PERF_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rs1,
    input  logic [REG_ADDR_W-1:0] ex_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  wb_reg_write,
    input  logic                  branch_taken,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_bubble,
    output logic [1:0]            fwd_a,
    output logic [1:0]            fwd_b,
    output logic                  stall_active,
    output logic [PERF_W-1:0]     stall_count
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);
    localparam bit MULTI_CYCLE = (LOAD_LAT > 1);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             lu;
    logic             raw_stall;

    // x0 is hardwired to zero, so it never creates a dependency.
    function automatic logic m(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  used,
        input logic [REG_ADDR_W-1:0] rd,
        input logic                  we
    );
        return used && we && (rd != '0) && (rd == rs);
    endfunction

    assign lu = ex_mem_read &&
                (m(id_rs1, id_rs1_used, ex_rd, 1'b1) || m(id_rs2, id_rs2_used, ex_rd, 1'b1));

`ifdef HAZARD_FWD_EN
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) return 2'b10;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs)) return 2'b01;
        else return 2'b00;
    endfunction

    assign fwd_a     = fwd_sel(ex_rs1);
    assign fwd_b     = fwd_sel(ex_rs2);
    assign raw_stall = 1'b0;

    logic unused_nofwd_inputs;
    assign unused_nofwd_inputs = ex_reg_write;
`else
    assign fwd_a = 2'b00;
    assign fwd_b = 2'b00;
    // Writeback is not checked: the register file writes before it reads.
    assign raw_stall = m(id_rs1, id_rs1_used, ex_rd, ex_reg_write)
                    || m(id_rs2, id_rs2_used, ex_rd, ex_reg_write)
                    || m(id_rs1, id_rs1_used, mem_rd, mem_reg_write)
                    || m(id_rs2, id_rs2_used, mem_rd, mem_reg_write);

    logic unused_fwd_inputs;
    assign unused_fwd_inputs = ^{ex_rs1, ex_rs2, wb_rd, wb_reg_write};
`endif

    assign stall_active = (state == STALL);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if ((state == STALL) || lu || raw_stall) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // The detection cycle is the first stall cycle, so STALL covers the remaining LOAD_LAT-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (branch_taken) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lu && MULTI_CYCLE) begin
                        state <= STALL;
                        cnt   <= CNT_W'(LOAD_LAT - 1);
                    end
                end
                STALL: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
        end else if (!pc_write && (stall_count != '1)) begin
            stall_count <= stall_count + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (LOAD_LAT=3, 4-bit stall counter to reach saturation).
module tb_hazard_unit;

    localparam int AW = 5;
    localparam int PW = 4;
`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, stall_active, fwd_a, fwd_b}
    localparam logic [8:0] RUN = 9'b1_1_0_0_0_00_00;
    localparam logic [8:0] DET = 9'b0_0_0_1_0_00_00;
    localparam logic [8:0] STL = 9'b0_0_0_1_1_00_00;
    localparam logic [8:0] BRI = 9'b1_1_1_1_0_00_00;
    localparam logic [8:0] BRS = 9'b1_1_1_1_1_00_00;
    localparam logic [8:0] RAWX = FWD ? RUN : DET;
    localparam logic [1:0] F10 = FWD ? 2'b10 : 2'b00;
    localparam logic [1:0] F01 = FWD ? 2'b01 : 2'b00;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic          id_rs1_used, id_rs2_used, ex_reg_write, ex_mem_read;
    logic          mem_reg_write, wb_reg_write, branch_taken;
    logic          pc_write, if_id_write, if_id_flush, id_ex_bubble, stall_active;
    logic [1:0]    fwd_a, fwd_b;
    logic [PW-1:0] stall_count;
    logic [8:0]    obs;

    logic [8:0]    exp_q[$];
    logic [PW-1:0] exp_sc;
    int            checks = 0;
    int            errors = 0;

    hazard_unit #(.REG_ADDR_W(AW), .LOAD_LAT(3), .PERF_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .branch_taken(branch_taken),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_active(stall_active), .stall_count(stall_count)
    );

    assign obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, stall_active, fwd_a, fwd_b};

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
        return (v == '1) ? v : v + PW'(1);
    endfunction

    // driver tasks
    task automatic clear_inputs();
        id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic drive_lu(input bit on);
        ex_mem_read = on; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = on;
    endtask

    task automatic test_reset();
        logic [8:0] e;
        clear_inputs();
        rst_n = 1'b0;
        exp_sc = '0;
        #3;
        exp_q.push_back(RUN);
        e = exp_q.pop_front();
        checks++; if (obs !== e) begin errors++; $display("FAIL reset_held outputs: got %b expected %b", obs, e); end
        checks++; if (stall_count !== exp_sc) begin errors++; $display("FAIL reset_held stall_count: got %0d expected %0d", stall_count, exp_sc); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(RUN);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (obs !== e) begin errors++; $display("FAIL reset_release[%0d] outputs: got %b expected %b", i, obs, e); end
            checks++; if (stall_count !== exp_sc) begin errors++; $display("FAIL reset_release[%0d] stall_count: got %0d expected %0d", i, stall_count, exp_sc); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        logic [8:0] seq [5];
        logic [8:0] e;
        seq = '{DET, STL, STL, RUN, RUN};
        for (int i = 0; i < 5; i++) begin
            drive_lu(i == 0);
            exp_q.push_back(seq[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (obs !== e) begin errors++; $display("FAIL load_use[%0d] outputs: got %b expected %b", i, obs, e); end
            checks++; if (stall_count !== exp_sc) begin errors++; $display("FAIL load_use[%0d] stall_count: got %0d expected %0d", i, stall_count, exp_sc); end
            if (!e[8]) exp_sc = sat_inc(exp_sc);
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_no_stall();
        logic [8:0] seq [7];
        logic [8:0] e;
        seq = '{RUN, RUN, RUN, DET, STL, STL, RUN};
        for (int i = 0; i < 7; i++) begin
            clear_inputs();
            case (i)
                0: begin ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1; end
                1: begin ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b0; end
                2: begin ex_mem_read = 1'b0; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1; end
                3: begin ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_rs2_used = 1'b1;
                         id_rs1 = 5'd9; id_rs1_used = 1'b0; end
                default: ;
            endcase
            exp_q.push_back(seq[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (obs !== e) begin errors++; $display("FAIL no_stall[%0d] outputs: got %b expected %b", i, obs, e); end
            checks++; if (stall_count !== exp_sc) begin errors++; $display("FAIL no_stall[%0d] stall_count: got %0d expected %0d", i, stall_count, exp_sc); end
            if (!e[8]) exp_sc = sat_inc(exp_sc);
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_forwarding();
        logic [8:0] e;
        logic [1:0] fa [6];
        logic [1:0] fb [6];
        fa = '{2'b00, 2'b00, F10, F01, 2'b00, 2'b00};
        fb = '{F10, F01, F10, F01, 2'b00, F01};
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_write = 1'b1; wb_reg_write = 1'b1; ex_rs2 = 5'd7;
            case (i)
                1: mem_reg_write = 1'b0;
                2: ex_rs1 = 5'd7;
                3: begin ex_rs1 = 5'd7; mem_rd = 5'd0; end
                4: begin ex_rs1 = 5'd7; mem_rd = 5'd0; wb_rd = 5'd0; end
                5: begin ex_rs1 = 5'd0; mem_rd = 5'd0; end
                default: ;
            endcase
            exp_q.push_back({5'b11000, fa[i], fb[i]});
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (obs !== e) begin errors++; $display("FAIL forwarding[%0d] outputs: got %b expected %b", i, obs, e); end
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_raw_stall();
        logic [8:0] seq [6];
        logic [8:0] e;
        seq = '{RAWX, RUN, RAWX, RUN, RUN, RUN};
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            case (i)
                0: begin ex_reg_write = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_rs2_used = 1'b1; end
                1: begin ex_reg_write = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_rs2_used = 1'b0; end
                2: begin mem_reg_write = 1'b1; mem_rd = 5'd4; id_rs1 = 5'd4; id_rs1_used = 1'b1; end
                3: begin wb_reg_write = 1'b1; wb_rd = 5'd6; id_rs1 = 5'd6; id_rs1_used = 1'b1; end
                4: begin ex_reg_write = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_used = 1'b1; end
                default: ;
            endcase
            exp_q.push_back(seq[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (obs !== e) begin errors++; $display("FAIL raw_stall[%0d] outputs: got %b expected %b", i, obs, e); end
            checks++; if (stall_count !== exp_sc) begin errors++; $display("FAIL raw_stall[%0d] stall_count: got %0d expected %0d", i, stall_count, exp_sc); end
            if (!e[8]) exp_sc = sat_inc(exp_sc);
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_branch();
        logic [8:0] seq [6];
        logic [8:0] e;
        seq = '{DET, BRS, RUN, RUN, BRI, RUN};
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            if (i == 0 || i == 4) drive_lu(1'b1);
            if (i == 1 || i == 4) branch_taken = 1'b1;
            exp_q.push_back(seq[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (obs !== e) begin errors++; $display("FAIL branch[%0d] outputs: got %b expected %b", i, obs, e); end
            checks++; if (stall_count !== exp_sc) begin errors++; $display("FAIL branch[%0d] stall_count: got %0d expected %0d", i, stall_count, exp_sc); end
            if (!e[8]) exp_sc = sat_inc(exp_sc);
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic [8:0] e;
        for (int i = 0; i < 14; i++) begin
            drive_lu(i < 12);
            // lu held: detection, two STALL cycles, then re-detected in the next IDLE cycle
            exp_q.push_back((i >= 12) ? RUN : ((i % 3 == 0) ? DET : STL));
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (obs !== e) begin errors++; $display("FAIL back_to_back[%0d] outputs: got %b expected %b", i, obs, e); end
            checks++; if (stall_count !== exp_sc) begin errors++; $display("FAIL back_to_back[%0d] stall_count: got %0d expected %0d", i, stall_count, exp_sc); end
            if (!e[8]) exp_sc = sat_inc(exp_sc);
            @(posedge clk); #1;
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_stall();
        logic [8:0] seq [2];
        logic [8:0] e;
        seq = '{DET, STL};
        for (int i = 0; i < 2; i++) begin
            drive_lu(i == 0);
            exp_q.push_back(seq[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (obs !== e) begin errors++; $display("FAIL reset_mid_stall[%0d] outputs: got %b expected %b", i, obs, e); end
            if (!e[8] && i == 0) exp_sc = sat_inc(exp_sc);
            if (i == 0) begin @(posedge clk); #1; end
        end
        #1 rst_n = 1'b0;
        exp_sc = '0;
        #1;
        exp_q.push_back(RUN);
        e = exp_q.pop_front();
        checks++; if (obs !== e) begin errors++; $display("FAIL reset_mid_stall async outputs: got %b expected %b", obs, e); end
        checks++; if (stall_count !== exp_sc) begin errors++; $display("FAIL reset_mid_stall async stall_count: got %0d expected %0d", stall_count, exp_sc); end
        @(posedge clk); #1 rst_n = 1'b1;
        clear_inputs();
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(RUN);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++; if (obs !== e) begin errors++; $display("FAIL reset_mid_stall_after[%0d] outputs: got %b expected %b", i, obs, e); end
            checks++; if (stall_count !== exp_sc) begin errors++; $display("FAIL reset_mid_stall_after[%0d] stall_count: got %0d expected %0d", i, stall_count, exp_sc); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_stall();
        test_forwarding();
        test_raw_stall();
        test_branch();
        test_back_to_back();
        test_reset_mid_stall();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
